// File: rtl/dcache_ctrl_if.sv
// rtl/dcache_ctrl_if.sv - CPU-side and memory-side signal bundle for dcache_ctrl
interface dcache_ctrl_if #(
  parameter int LINE_BITS = 256
);
  logic                 cpu_MemRead_i;
  logic                 cpu_MemWrite_i;
  logic [31:0]          cpu_addr_i;
  logic [31:0]          cpu_data_i;
  logic [31:0]          cpu_data_o;
  logic                 cpu_stall_o;
  logic                 mem_enable_o;
  logic                 mem_write_o;
  logic [31:0]          mem_addr_o;
  logic [LINE_BITS-1:0] mem_data_o;
  logic [LINE_BITS-1:0] mem_data_i;
  logic                 mem_ack_i;

  // Cache side.
  modport slave (
    input  cpu_MemRead_i, cpu_MemWrite_i, cpu_addr_i, cpu_data_i, mem_data_i, mem_ack_i,
    output cpu_data_o, cpu_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );

  // Pipeline and memory side.
  modport master (
    output cpu_MemRead_i, cpu_MemWrite_i, cpu_addr_i, cpu_data_i, mem_data_i, mem_ack_i,
    input  cpu_data_o, cpu_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );
endinterface

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-back write-allocate L1 data cache controller
module dcache_ctrl #(
  parameter int LINE_BITS = 256,
  parameter int INDEX_W   = 5,
  parameter int OFFSET_W  = 5
) (
  input  logic         clk_i,
  input  logic         rst_i,
  dcache_ctrl_if.slave bus
);
  localparam int TAG_W  = 32 - INDEX_W - OFFSET_W;
  localparam int LINES  = 1 << INDEX_W;
  localparam int WORD_W = OFFSET_W - 2;

  typedef enum logic [1:0] {IDLE, WB_REQ, FILL_REQ, RD_DONE} state_t;

  state_t state_q, state_d;

  logic [LINES-1:0]     valid_q;
  logic [LINES-1:0]     dirty_q;
  logic [TAG_W-1:0]     tag_q  [LINES];
  logic [LINE_BITS-1:0] data_q [LINES];

  logic [TAG_W-1:0]     cpu_tag;
  logic [INDEX_W-1:0]   cpu_index;
  logic [WORD_W-1:0]    cpu_word;
  logic [1:0]           unused_byte_sel;

  logic                 req;
  logic                 hit;
  logic                 victim_dirty;
  logic                 miss_launch;
  logic                 store_en;
  logic                 fill_done;
  logic [TAG_W-1:0]     victim_tag;
  logic [LINE_BITS-1:0] cur_line;
  logic [LINE_BITS-1:0] merged_line;
  logic [31:0]          victim_addr;
  logic [31:0]          fill_addr;

  assign cpu_tag         = bus.cpu_addr_i[31 -: TAG_W];
  assign cpu_index       = bus.cpu_addr_i[OFFSET_W +: INDEX_W];
  assign cpu_word        = bus.cpu_addr_i[2 +: WORD_W];
  assign unused_byte_sel = bus.cpu_addr_i[1:0];

  assign cur_line     = data_q[cpu_index];
  assign victim_tag   = tag_q[cpu_index];
  assign req          = bus.cpu_MemRead_i | bus.cpu_MemWrite_i;
  assign hit          = valid_q[cpu_index] & (victim_tag == cpu_tag);
  assign victim_dirty = valid_q[cpu_index] & dirty_q[cpu_index];
  assign victim_addr  = {victim_tag, cpu_index, {OFFSET_W{1'b0}}};
  assign fill_addr    = {cpu_tag, cpu_index, {OFFSET_W{1'b0}}};

  // A miss launches its memory request in the detecting cycle so memory latency
  // starts counting immediately; reset masks it so the bus is quiet while held.
  assign miss_launch = rst_i & req & ~hit & (state_q == IDLE);

  // Stores complete on a hit in IDLE or once the missing line has arrived.
  assign store_en  = bus.cpu_MemWrite_i & hit & ((state_q == IDLE) | (state_q == RD_DONE));
  assign fill_done = (state_q == FILL_REQ) & bus.mem_ack_i;

  assign bus.cpu_stall_o = req & ~hit & (state_q != RD_DONE);
  assign bus.cpu_data_o  = (bus.cpu_MemRead_i & ~bus.cpu_MemWrite_i & hit)
                           ? cur_line[int'(cpu_word) * 32 +: 32] : 32'd0;

  // Current line with the store word replaced.
  always_comb begin
    merged_line = cur_line;
    merged_line[int'(cpu_word) * 32 +: 32] = bus.cpu_data_i;
  end

  // Next-state and memory request outputs.
  always_comb begin
    state_d          = state_q;
    bus.mem_enable_o = 1'b0;
    bus.mem_write_o  = 1'b0;
    bus.mem_addr_o   = 32'd0;
    bus.mem_data_o   = '0;
    case (state_q)
      IDLE: begin
        if (miss_launch) begin
          bus.mem_enable_o = 1'b1;
          if (victim_dirty) begin
            state_d         = WB_REQ;
            bus.mem_write_o = 1'b1;
            bus.mem_addr_o  = victim_addr;
            bus.mem_data_o  = cur_line;
          end else begin
            state_d        = FILL_REQ;
            bus.mem_addr_o = fill_addr;
          end
        end
      end
      WB_REQ: begin
        bus.mem_enable_o = 1'b1;
        bus.mem_write_o  = 1'b1;
        bus.mem_addr_o   = victim_addr;
        bus.mem_data_o   = cur_line;
        if (bus.mem_ack_i) state_d = FILL_REQ;
      end
      FILL_REQ: begin
        bus.mem_enable_o = 1'b1;
        bus.mem_addr_o   = fill_addr;
        if (bus.mem_ack_i) state_d = RD_DONE;
      end
      RD_DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Line storage: fills replace a whole line, stores merge one word and mark it dirty.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
      for (int i = 0; i < LINES; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else if (fill_done) begin
      valid_q[cpu_index] <= 1'b1;
      dirty_q[cpu_index] <= 1'b0;
      tag_q[cpu_index]   <= cpu_tag;
      data_q[cpu_index]  <= bus.mem_data_i;
    end else if (store_en) begin
      dirty_q[cpu_index] <= 1'b1;
      data_q[cpu_index]  <= merged_line;
    end
  end
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - scoreboard bench for dcache_ctrl with a latency-L line memory
module tb_dcache_ctrl;
  localparam int L = 10;

  typedef struct {
    logic        is_read;
    logic [31:0] data;
    int          stall;
  } cpu_exp_t;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic        chk;
    logic [2:0]  word;
    logic [31:0] val;
  } mem_exp_t;

  logic clk_i = 1'b0;
  logic rst_i;
  logic force_ack;
  int   checks = 0;
  int   errors = 0;

  cpu_exp_t      cpu_q[$];
  mem_exp_t      mem_q[$];
  logic [255:0]  mem_lines [logic [26:0]];

  always #5 clk_i = ~clk_i;

  dcache_ctrl_if #(.LINE_BITS(256)) bus ();

  dcache_ctrl dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  function automatic logic [255:0] pattern_line(input logic [26:0] la);
    logic [255:0] ln;
    logic [31:0]  a;
    ln = '0;
    for (int w = 0; w < 8; w++) begin
      a = {la, 5'b0} + 32'(w * 4);
      ln[w * 32 +: 32] = {16'hA5A5, a[15:0]};
    end
    return ln;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic exp_mem(input logic wr, input logic [31:0] a, input logic c,
                         input logic [2:0] w, input logic [31:0] v);
    mem_exp_t m;
    m.wr = wr; m.addr = a; m.chk = c; m.word = w; m.val = v;
    mem_q.push_back(m);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    forever begin
      @(negedge clk_i); #1;
      if (rst_i && !bus.cpu_stall_o) break;
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL %s timeout actual=stalled required=done", name);
        break;
      end
    end
    @(posedge clk_i); #1;
    bus.cpu_MemRead_i  = 1'b0;
    bus.cpu_MemWrite_i = 1'b0;
  endtask

  task automatic start(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] exp_data, input int exp_stall);
    cpu_exp_t e;
    e.is_read = rd & ~wr; e.data = exp_data; e.stall = exp_stall;
    cpu_q.push_back(e);
    bus.cpu_MemRead_i  = rd;
    bus.cpu_MemWrite_i = wr;
    bus.cpu_addr_i     = a;
    bus.cpu_data_i     = d;
  endtask

  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp_data, input int exp_stall);
    start(rd, wr, a, d, exp_data, exp_stall);
    wait_done("access");
  endtask

  // Memory model: acks L cycles after a request starts; a request starts when
  // enable rises or continues straight after an ack (write-back then fill).
  initial begin
    int           cnt;
    logic         prev_en, prev_ack, ack_now;
    logic [26:0]  la;
    mem_exp_t     m;
    cnt = 0; prev_en = 1'b0; prev_ack = 1'b0;
    bus.mem_ack_i  = 1'b0;
    bus.mem_data_i = '0;
    forever begin
      @(negedge clk_i);
      ack_now = 1'b0;
      if (bus.mem_enable_o) begin
        if (!prev_en || prev_ack) cnt = 0;
        else cnt++;
        ack_now = (cnt == L);
      end else begin
        cnt = 0;
      end
      if (ack_now) begin
        la = bus.mem_addr_o[31:5];
        if (mem_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mem_unexpected actual=%0h required=none", bus.mem_addr_o);
        end else begin
          m = mem_q.pop_front();
          chk("mem_write", 256'(bus.mem_write_o), 256'(m.wr));
          chk("mem_addr", 256'(bus.mem_addr_o), 256'(m.addr));
          if (m.chk) chk("wb_word", 256'(bus.mem_data_o[int'(m.word) * 32 +: 32]), 256'(m.val));
        end
        if (bus.mem_write_o) mem_lines[la] = bus.mem_data_o;
        else bus.mem_data_i = mem_lines.exists(la) ? mem_lines[la] : pattern_line(la);
      end
      prev_en  = bus.mem_enable_o;
      prev_ack = ack_now;
      bus.mem_ack_i = ack_now | force_ack;
    end
  end

  // CPU monitor: counts stalled cycles of each access and checks it on completion.
  initial begin
    int       stall_cnt;
    cpu_exp_t e;
    stall_cnt = 0;
    forever begin
      @(negedge clk_i); #1;
      if (!rst_i) begin
        stall_cnt = 0;
      end else if (bus.cpu_MemRead_i || bus.cpu_MemWrite_i) begin
        if (bus.cpu_stall_o) begin
          stall_cnt++;
        end else begin
          if (cpu_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL cpu_unexpected actual=%0h required=none", bus.cpu_addr_i);
          end else begin
            e = cpu_q.pop_front();
            chk("stall_cycles", 256'(stall_cnt), 256'(e.stall));
            if (e.is_read) chk("load_data", 256'(bus.cpu_data_o), 256'(e.data));
          end
          stall_cnt = 0;
        end
      end
    end
  end

  // Directed stimulus.
  initial begin
    logic [255:0] ln;
    ln = pattern_line(27'h2);
    ln[31:0] = 32'h1111_2222;
    mem_lines[27'h2] = ln;

    force_ack          = 1'b0;
    rst_i              = 1'b0;
    bus.cpu_MemRead_i  = 1'b0;
    bus.cpu_MemWrite_i = 1'b0;
    bus.cpu_addr_i     = 32'd0;
    bus.cpu_data_i     = 32'd0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_stall", 256'(bus.cpu_stall_o), 256'(0));
    chk("rst_data", 256'(bus.cpu_data_o), 256'(0));
    chk("rst_mem_en", 256'(bus.mem_enable_o), 256'(0));
    chk("rst_mem_wr", 256'(bus.mem_write_o), 256'(0));
    chk("rst_mem_addr", 256'(bus.mem_addr_o), 256'(0));
    chk("rst_mem_data", bus.mem_data_o, 256'(0));
    rst_i = 1'b1;
    @(posedge clk_i); #1;

    // Clean read miss, write hit, read hit.
    exp_mem(1'b0, 32'h40, 1'b0, 3'd0, 32'h0);
    access(1'b1, 1'b0, 32'h40, 32'h0, 32'h1111_2222, L + 1);
    access(1'b0, 1'b1, 32'h44, 32'hDEAD_BEEF, 32'h0, 0);
    access(1'b1, 1'b0, 32'h44, 32'h0, 32'hDEAD_BEEF, 0);

    // Ack pulses while idle on a hit are ignored.
    force_ack = 1'b1;
    access(1'b1, 1'b0, 32'h44, 32'h0, 32'hDEAD_BEEF, 0);
    force_ack = 1'b0;
    chk("idle_ack_no_req", 256'(bus.mem_enable_o), 256'(0));
    access(1'b1, 1'b0, 32'h40, 32'h0, 32'h1111_2222, 0);

    // Dirty eviction: write-back of 0x40 then fill of 0x440.
    exp_mem(1'b1, 32'h40, 1'b1, 3'd1, 32'hDEAD_BEEF);
    exp_mem(1'b0, 32'h440, 1'b0, 3'd0, 32'h0);
    access(1'b1, 1'b0, 32'h440, 32'h0, 32'hA5A5_0440, 2 * L + 2);

    // Write miss with clean victim, merged after the fill.
    exp_mem(1'b0, 32'h880, 1'b0, 3'd0, 32'h0);
    access(1'b0, 1'b1, 32'h880, 32'h1234_5678, 32'h0, L + 1);
    access(1'b1, 1'b0, 32'h880, 32'h0, 32'h1234_5678, 0);
    access(1'b1, 1'b0, 32'h886, 32'h0, 32'hA5A5_0884, 0);

    // The merged line is dirty: evicting it writes it back.
    exp_mem(1'b1, 32'h880, 1'b1, 3'd0, 32'h1234_5678);
    exp_mem(1'b0, 32'h80, 1'b0, 3'd0, 32'h0);
    access(1'b1, 1'b0, 32'h80, 32'h0, 32'hA5A5_0080, 2 * L + 2);

    // Reset in the 5th cycle of a fill abandons it; the read restarts from IDLE.
    exp_mem(1'b0, 32'h1000, 1'b0, 3'd0, 32'h0);
    start(1'b1, 1'b0, 32'h1000, 32'h0, 32'hA5A5_1000, L + 1);
    repeat (4) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    #1;
    chk("abort_mem_en", 256'(bus.mem_enable_o), 256'(0));
    chk("abort_mem_wr", 256'(bus.mem_write_o), 256'(0));
    chk("abort_mem_addr", 256'(bus.mem_addr_o), 256'(0));
    chk("abort_stall", 256'(bus.cpu_stall_o), 256'(1));
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    wait_done("reset_refill");

    // Lines resident before reset miss again; memory holds the written-back data.
    exp_mem(1'b0, 32'h440, 1'b0, 3'd0, 32'h0);
    access(1'b1, 1'b0, 32'h440, 32'h0, 32'hA5A5_0440, L + 1);
    exp_mem(1'b0, 32'h40, 1'b0, 3'd0, 32'h0);
    access(1'b1, 1'b0, 32'h44, 32'h0, 32'hDEAD_BEEF, L + 1);
    access(1'b1, 1'b0, 32'h40, 32'h0, 32'h1111_2222, 0);

    repeat (3) @(posedge clk_i);
    #1;
    chk("cpu_q_drained", 256'(cpu_q.size()), 256'(0));
    chk("mem_q_drained", 256'(mem_q.size()), 256'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate L1 data cache controller for the MEM stage of the pipelined CPU.
- Consumes the EX/MEM outputs: MemRead, MemWrite, ALU result used as the address, and RS data2 used as the store data.
- Returns load data to MEM/WB and drives the pipeline-wide stall that freezes PC, IF/ID, ID/EX, EX/MEM and MEM/WB while a miss is serviced.
- Talks to off-chip data memory through a line-wide enable/ack handshake.

Parameters:
- LINE_BITS, 256, cache line width in bits (32 bytes; 8 words).
- INDEX_W, 5, index bits; 32 lines.
- OFFSET_W, 5, byte-offset bits within a line.

Ports:
- clk_i  in  1  clock; all state updates on posedge.
- rst_i  in  1  asynchronous, active-low reset.
- cpu_MemRead_i  in  1  load request from EX/MEM.
- cpu_MemWrite_i  in  1  store request from EX/MEM.
- cpu_addr_i  in  32  byte address (EX/MEM ALU result).
- cpu_data_i  in  32  store data (EX/MEM RS data2).
- cpu_data_o  out  32  load data; combinational on hit.
- cpu_stall_o  out  1  pipeline stall; combinational.
- mem_enable_o  out  1  memory request valid.
- mem_write_o  out  1  1 = line write-back, 0 = line fill.
- mem_addr_o  out  32  line-aligned memory address; low OFFSET_W bits are 0.
- mem_data_o  out  LINE_BITS  victim line for write-back.
- mem_data_i  in  LINE_BITS  fill line.
- mem_ack_i  in  1  one-cycle completion pulse from memory.

Behaviour:
- Address split:
  - tag = addr[31:INDEX_W+OFFSET_W]; 22 bits at the defaults.
  - index = addr[OFFSET_W+INDEX_W-1:OFFSET_W].
  - word = addr[OFFSET_W-1:2].
  - addr[1:0] are ignored.
- Storage: per line, one valid bit, one dirty bit, a tag, and LINE_BITS of data, all held in internal registers.
- Request and hit/miss:
  - req = cpu_MemRead_i | cpu_MemWrite_i.
  - hit = valid[index] & tag match.
  - If both read and write are asserted, the access is handled as a write.
- cpu_stall_o = req & ~hit & (state != RD_DONE), evaluated combinationally in the same cycle the request is presented.
  - With no request, cpu_stall_o = 0.
- Read hit:
  - cpu_data_o = the selected word, zero latency.
  - cpu_data_o = 0 when there is no read hit.
- Write hit:
  - On the posedge, the selected word is replaced with cpu_data_i and dirty[index] is set.
  - Other words in the line are unchanged.
- FSM states: IDLE, WB_REQ, FILL_REQ, RD_DONE.
  - IDLE:
    - req & miss & dirty victim -> WB_REQ.
    - req & miss & clean/invalid victim -> FILL_REQ.
    - Otherwise stay in IDLE.
  - WB_REQ:
    - Drives mem_enable_o=1, mem_write_o=1, mem_addr_o={victim tag, index, 0}, mem_data_o=victim line.
    - On mem_ack_i -> FILL_REQ.
  - FILL_REQ:
    - Drives mem_enable_o=1, mem_write_o=0, mem_addr_o={cpu tag, index, 0}.
    - On mem_ack_i, capture mem_data_i into the line, set valid=1, dirty=0, update the tag -> RD_DONE.
  - RD_DONE:
    - Stall deasserts and the access completes as a hit.
    - A pending write merges cpu_data_i into the line and sets dirty.
    - Next state is IDLE.
- Memory handshake:
  - mem_enable_o and its address/data stay stable from entry into WB_REQ/FILL_REQ until the ack cycle inclusive.
  - mem_enable_o drops in the cycle after the ack.
  - mem_ack_i is ignored in IDLE and RD_DONE.
- Miss latency seen by the CPU, with memory ack latency L cycles after enable:
  - Clean miss: stall for L+1 cycles.
  - Dirty miss: stall for 2L+2 cycles.
- Reset (rst_i=0, any time, including mid-miss):
  - state=IDLE; all valid and dirty bits cleared; tags and data zeroed.
  - mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0.
  - cpu_stall_o and cpu_data_o follow the combinational rules and read 0 while no request is present.
  - An in-flight memory transaction is abandoned; the memory model must tolerate a dropped enable.
- Index/tag aliasing: two addresses with the same index and different tags evict each other. No other replacement policy.

Test Plan:
- Reset, then a read of 0x0000_0040 with memory latency 10 and memory holding 0x1111_2222 at word 0 -> stall=1 for 11 cycles, one fill at mem_addr_o=0x40, then cpu_data_o=0x1111_2222 with stall=0.
- Write 0xDEAD_BEEF to 0x44 after the line is resident -> no stall; the next read of 0x44 returns 0xDEAD_BEEF; dirty[2]=1.
- Read 0x0000_0440 (same index 2, new tag) after the dirty write -> write-back at mem_addr_o=0x40 whose line data carries 0xDEAD_BEEF in word 1, then a fill at 0x440; stall lasts 22 cycles.
- Write miss to 0x0000_0880 with a clean victim -> fill only; the word merges in RD_DONE; the following read of 0x880 returns the written value and the line is dirty.
- Assert rst_i=0 in the 5th cycle of a fill -> mem_enable_o=0 immediately (asynchronous); after release the same read misses again from IDLE.
- Drive mem_ack_i=1 while in IDLE with a read hit on 0x44 -> no state change; data is correct and stall=0.
